config_load_ctrl: RTL and testbench
===================================

# config_load_ctrl

Sequences configuration loading into the per-core configuration memory. Accepts a 32-bit valid/ready word stream from the NoC configuration channel, decodes a two-word burst header, and issues one registered write per data word to the selected parameter memory with an auto-incrementing address. A hold input lets the neuron core block configuration writes while it is reading configuration ports.

## Interface
Parameters:
- NURN_CNT_BIT_WIDTH, 8: neuron index width
- AXON_CNT_BIT_WIDTH, 8: axon index width
- DSIZE, 16: data word half-width; the stream word is DSIZE*2 bits
- CONFIG_PARAMETER_NUMBER, 9: number of write-strobe targets

Ports:
- clk_i, in, 1: clock
- rst_n_i, in, 1: asynchronous active-low reset
- cfg_data_i, in, DSIZE*2: stream word
- cfg_valid_i, in, 1: stream word valid
- cfg_ready_o, out, 1: stream word accepted when valid and ready are both high
- cfg_hold_i, in, 1: core busy; while high, no word is accepted
- config_data_in, out, DSIZE*2: write data to config memory
- config_write_enable, out, CONFIG_PARAMETER_NUMBER: one-hot write strobe, bit index = select
- config_write_address, out, NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH (ADDRW): write address
- busy_o, out, 1: a burst is in progress (state not HDR0)
- done_o, out, 1: one-cycle pulse coincident with the last write of a burst
- err_o, out, 1: sticky flag for an illegal select; cleared at the next accepted H0

## Operation
- Header H0: [31:28] select, [15:0] length minus 1. Header H1: [ADDRW-1:0] start address. Then length data words follow.
- Select 0..8 order: LTP_LTD_Window, LTP_LTD_LearnRate, LearnMode_Bias, NeuronType_RandomThreshold, Mask_RestPotential, AER, FixedThreshold, LearnMode_weight, Number_Neuron_Axon.
- The FSM has three states:
  - HDR0: on accept, latch select and length, go to HDR1.
  - HDR1: on accept, latch the address, go to DATA.
  - DATA: on accept, issue a write. Then address +1 and remaining count −1. On the last word, go to HDR0.
- Illegal select (≥ CONFIG_PARAMETER_NUMBER):
  - err_o is set at the H0 accept.
  - The burst is still consumed (H1 plus length words) with all strobes at 0.
  - done_o still pulses at the last word.
- Address wraps from 2^ADDRW−1 to 0 with no flag.
- Remaining count is 17 bits, so a length field of 0xFFFF yields 65536 words.
- cfg_ready_o = !cfg_hold_i, combinational from hold only. It is independent of state because every state can accept a word.
- Hold asserted mid-burst pauses acceptance and preserves state, address and count. The write for a word accepted in the cycle before hold rises still issues.

## Timing
- Reset values:
  - state = HDR0
  - config_write_enable = 0, config_write_address = 0, config_data_in = 0
  - busy_o = 0, done_o = 0, err_o = 0
  - cfg_ready_o follows cfg_hold_i
- Write latency is 1: a data word accepted at edge N drives config_data_in, config_write_address and strobe for cycle N+1.
- Strobe is high for exactly one cycle per accepted data word.
- Back-to-back data words produce consecutive-cycle writes at consecutive addresses.
- done_o is high in the same cycle as the final strobe.
- busy_o rises the cycle after H0 accept and falls the cycle after the last data accept.
- Bursts may be back to back: an H0 in the cycle after the last data word is accepted normally.
- Reset mid-burst aborts immediately. Any partially written memory contents stay as written.

## Structure
- Shared package config_pkg holds:
  - select encodings (CFG_SEL_LTP_LTD_WIN … CFG_SEL_NUM_NURN_AXON)
  - header field positions (H0_SEL_MSB/LSB, H0_LEN_MSB/LSB)
  - CONFIG_PARAMETER_NUMBER default
- The block is a single module with no sub-module; the FSM and the datapath are small enough to stay together.
- The one-hot decode is a function in config_pkg, shared with the core's config-memory instantiation.

## Test plan
- Basic burst: H0=0x5000_0002, H1=0x0010, data A,B,C with hold=0 → AER strobe (bit5) in three consecutive cycles at addresses 0x10,0x11,0x12 with data A,B,C; done_o with C; busy_o low afterwards.
- Wrap-around: select 7, length 2 (H0=0x7000_0001), H1=0xFFFF → writes at 0xFFFF then 0x0000; bit7 strobes only.
- Illegal select: H0=0xC000_0000, H1, one data word → err_o=1, no strobe, done_o pulses. A following legal H0 clears err_o.
- Hold mid-burst: hold high for 5 cycles between words 2 and 3 of a 4-word burst → cfg_ready_o=0 throughout; no strobes during hold; address continues at start+2 after release.
- Reset mid-burst: assert rst_n_i=0 after 1 of 4 data words → all outputs 0. A new burst with select 0 after release writes from its own H1 address.
- Max length: H0 length field 0xFFFF, select 8 → 65536 strobes and exactly one done_o, on the final write.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration-load definitions: select encodings, burst header field
// positions and the write-strobe one-hot decode used by the config memory.
package config_pkg;

  localparam int CFG_PARAM_NUMBER_DEFAULT = 9;

  localparam int H0_SEL_MSB = 31;
  localparam int H0_SEL_LSB = 28;
  localparam int H0_LEN_MSB = 15;
  localparam int H0_LEN_LSB = 0;

  typedef enum logic [3:0] {
    CFG_SEL_LTP_LTD_WIN          = 4'd0,
    CFG_SEL_LTP_LTD_RATE         = 4'd1,
    CFG_SEL_LEARN_MODE_BIAS      = 4'd2,
    CFG_SEL_NEURON_TYPE_RAND_THR = 4'd3,
    CFG_SEL_MASK_REST_POT        = 4'd4,
    CFG_SEL_AER                  = 4'd5,
    CFG_SEL_FIXED_THR            = 4'd6,
    CFG_SEL_LEARN_MODE_WEIGHT    = 4'd7,
    CFG_SEL_NUM_NURN_AXON        = 4'd8
  } cfgSel_t;

  // Caller truncates to its strobe width and gates out-of-range selects.
  function automatic logic [15:0] cfgSelOneHot(input logic [3:0] sel);
    return 16'(1) << sel;
  endfunction

endpackage

// File: rtl/config_load_ctrl.sv
// Decodes the NoC configuration word stream (H0, H1, data...) into registered,
// address-incrementing writes to the per-core parameter memories.
module config_load_ctrl #(
  parameter int NURN_CNT_BIT_WIDTH      = 8,
  parameter int AXON_CNT_BIT_WIDTH      = 8,
  parameter int DSIZE                   = 16,
  parameter int CONFIG_PARAMETER_NUMBER = config_pkg::CFG_PARAM_NUMBER_DEFAULT
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n_i,
  input  logic [DSIZE*2-1:0]                               cfg_data_i,
  input  logic                                             cfg_valid_i,
  output logic                                             cfg_ready_o,
  input  logic                                             cfg_hold_i,
  output logic [DSIZE*2-1:0]                               config_data_in,
  output logic [CONFIG_PARAMETER_NUMBER-1:0]               config_write_enable,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_write_address,
  output logic                                             busy_o,
  output logic                                             done_o,
  output logic                                             err_o
);
  import config_pkg::*;

  localparam int ADDRW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

  typedef enum logic [1:0] {HDR0, HDR1, DATA} loadState_t;

  loadState_t        state;
  logic [3:0]        selReg;
  logic              selOk;
  logic [16:0]       remaining;
  logic [ADDRW-1:0]  addrReg;
  logic              accept;
  logic [3:0]        hdrSel;

  // Every state consumes a word, so readiness depends on the core hold only.
  assign cfg_ready_o = !cfg_hold_i;
  assign accept      = cfg_valid_i && !cfg_hold_i;
  assign hdrSel      = cfg_data_i[H0_SEL_MSB:H0_SEL_LSB];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state                <= HDR0;
      selReg               <= '0;
      selOk                <= 1'b0;
      remaining            <= '0;
      addrReg              <= '0;
      config_data_in       <= '0;
      config_write_enable  <= '0;
      config_write_address <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
      err_o                <= 1'b0;
    end else begin
      config_write_enable <= '0;
      done_o              <= 1'b0;
      case (state)
        HDR0: if (accept) begin
          selReg    <= hdrSel;
          selOk     <= (int'(hdrSel) < CONFIG_PARAMETER_NUMBER);
          err_o     <= !(int'(hdrSel) < CONFIG_PARAMETER_NUMBER);
          remaining <= {1'b0, cfg_data_i[H0_LEN_MSB:H0_LEN_LSB]} + 17'd1;
          busy_o    <= 1'b1;
          state     <= HDR1;
        end
        HDR1: if (accept) begin
          addrReg <= cfg_data_i[ADDRW-1:0];
          state   <= DATA;
        end
        DATA: if (accept) begin
          config_data_in       <= cfg_data_i;
          config_write_address <= addrReg;
          // Illegal selects still drain the burst, just without strobes.
          config_write_enable  <= selOk ? CONFIG_PARAMETER_NUMBER'(cfgSelOneHot(selReg)) : '0;
          addrReg              <= addrReg + ADDRW'(1);
          remaining            <= remaining - 17'd1;
          if (remaining == 17'd1) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= HDR0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_config_load_ctrl.sv
// Directed bench for config_load_ctrl: writes are captured at the falling edge
// and checked per scenario against hand-computed expectations.
module tb_config_load_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] cfg_data_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic        cfg_hold_i = 1'b0;
  logic [31:0] config_data_in;
  logic [8:0]  config_write_enable;
  logic [15:0] config_write_address;
  logic        busy_o, done_o, err_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [8:0]  en;
    logic [15:0] addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } wr_t;
  wr_t wlog[$];

  config_load_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_hold_i(cfg_hold_i),
    .config_data_in(config_data_in), .config_write_enable(config_write_enable),
    .config_write_address(config_write_address),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (config_write_enable != '0 || done_o)
      wlog.push_back('{config_write_enable, config_write_address, config_data_in, done_o, cyc});
  end

  task automatic put(input logic [31:0] w);
    cfg_data_i  = w;
    cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    cfg_valid_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; cfg_hold_i = 1'b1;
    @(negedge clk_i);
    total++;
    if ({config_write_enable, config_write_address, config_data_in, busy_o, done_o, err_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: en=%h addr=%h data=%h busy=%b done=%b err=%b, want all 0",
                      config_write_enable, config_write_address, config_data_in, busy_o, done_o, err_o);
    end
    total++;
    if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_hold: got %b want 0", cfg_ready_o); end
    cfg_hold_i = 1'b0; #1;
    total++;
    if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_nohold: got %b want 1", cfg_ready_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    logic [31:0] d [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    wlog.delete();
    put(32'h5000_0002);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", busy_o); end
    put(32'h0000_0010);
    for (int i = 0; i < 3; i++) put(d[i]);
    idle(3);
    total++;
    if (wlog.size() != 3) begin bad++; $display("FAIL basic_count: got %0d want 3", wlog.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wlog[i].en !== 9'h020 || wlog[i].addr !== 16'h0010 + 16'(i) || wlog[i].data !== d[i]
            || wlog[i].done !== (i == 2) || wlog[i].cyc != wlog[0].cyc + i) begin
          bad++; $display("FAIL basic_write%0d: en=%h addr=%h data=%h done=%b cyc+%0d want en=020 addr=%h data=%h done=%b cyc+%0d",
                          i, wlog[i].en, wlog[i].addr, wlog[i].data, wlog[i].done, wlog[i].cyc - wlog[0].cyc,
                          16'h0010 + 16'(i), d[i], (i == 2), i);
        end
      end
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", busy_o); end
  endtask

  task automatic test_wrap;
    wlog.delete();
    put(32'h7000_0001); put(32'h0000_FFFF); put(32'h1111_1111); put(32'h2222_2222);
    idle(3);
    total++;
    if (wlog.size() != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", wlog.size()); end
    else begin
      total++;
      if (wlog[0].addr !== 16'hFFFF || wlog[1].addr !== 16'h0000 || wlog[0].en !== 9'h080
          || wlog[1].en !== 9'h080 || wlog[1].done !== 1'b1) begin
        bad++; $display("FAIL wrap_writes: addr=%h,%h en=%h,%h done=%b want FFFF,0000 080,080 1",
                        wlog[0].addr, wlog[1].addr, wlog[0].en, wlog[1].en, wlog[1].done);
      end
    end
  endtask

  task automatic test_illegal;
    wlog.delete();
    put(32'hC000_0000);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL illegal_err_set: got %b want 1", err_o); end
    put(32'h0000_0020); put(32'hDEAD_BEEF);
    idle(3);
    total++;
    if (wlog.size() != 1 || wlog[0].en !== 9'h000 || wlog[0].done !== 1'b1) begin
      bad++; $display("FAIL illegal_drain: entries=%0d want 1 with en=000 done=1", wlog.size());
    end
    total++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL illegal_sticky: err=%b busy=%b want 1 0", err_o, busy_o);
    end
    wlog.delete();
    put(32'h1000_0000);
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL illegal_err_clear: got %b want 0", err_o); end
    put(32'h0000_0030); put(32'h0000_5555);
    idle(3);
    total++;
    if (wlog.size() != 1 || wlog[0].en !== 9'h002 || wlog[0].addr !== 16'h0030) begin
      bad++; $display("FAIL illegal_next_burst: entries=%0d want 1 write en=002 addr=0030", wlog.size());
    end
  endtask

  task automatic test_hold;
    logic [31:0] d [4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    wlog.delete();
    put(32'h2000_0003); put(32'h0000_0040); put(d[0]); put(d[1]);
    cfg_hold_i = 1'b1; cfg_data_i = d[2];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      total++;
      if (cfg_ready_o !== 1'b0 || (k > 0 && config_write_enable !== 9'h000)) begin
        bad++; $display("FAIL hold_cycle%0d: ready=%b en=%h want 0 000", k, cfg_ready_o, config_write_enable);
      end
      @(posedge clk_i); #1;
    end
    cfg_hold_i = 1'b0;
    put(d[2]); put(d[3]);
    idle(3);
    total++;
    if (wlog.size() != 4) begin bad++; $display("FAIL hold_count: got %0d want 4", wlog.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wlog[i].addr !== 16'h0040 + 16'(i) || wlog[i].data !== d[i] || wlog[i].en !== 9'h004
            || wlog[i].done !== (i == 3)) begin
          bad++; $display("FAIL hold_write%0d: addr=%h data=%h en=%h done=%b", i, wlog[i].addr,
                          wlog[i].data, wlog[i].en, wlog[i].done);
        end
      end
      total++;
      if (wlog[2].cyc - wlog[1].cyc != 6) begin
        bad++; $display("FAIL hold_gap: got %0d cycles want 6", wlog[2].cyc - wlog[1].cyc);
      end
    end
  endtask

  task automatic test_reset_mid;
    put(32'h3000_0003); put(32'h0000_0050); put(32'h0000_0077);
    cfg_valid_i = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({config_write_enable, config_write_address, config_data_in, busy_o, done_o, err_o} !== '0) begin
      bad++; $display("FAIL resetmid_outputs: en=%h addr=%h data=%h busy=%b done=%b err=%b want all 0",
                      config_write_enable, config_write_address, config_data_in, busy_o, done_o, err_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle(1);
    wlog.delete();
    put(32'h0000_0000); put(32'h0000_0060); put(32'h0000_1234);
    idle(3);
    total++;
    if (wlog.size() != 1 || wlog[0].en !== 9'h001 || wlog[0].addr !== 16'h0060 || wlog[0].done !== 1'b1) begin
      bad++; $display("FAIL resetmid_new_burst: entries=%0d want 1 write en=001 addr=0060 done=1", wlog.size());
    end
  endtask

  task automatic test_max_length;
    int badEn, doneCnt;
    wlog.delete();
    put(32'h8000_FFFF); put(32'h0000_0000);
    for (int i = 0; i < 65536; i++) put(32'(i));
    idle(3);
    total++;
    if (wlog.size() != 65536) begin bad++; $display("FAIL max_count: got %0d want 65536", wlog.size()); end
    else begin
      badEn = 0; doneCnt = 0;
      for (int i = 0; i < 65536; i++) begin
        if (wlog[i].en !== 9'h100 || wlog[i].addr !== 16'(i) || wlog[i].data !== 32'(i)) badEn++;
        if (wlog[i].done) doneCnt++;
      end
      total++;
      if (badEn != 0) begin bad++; $display("FAIL max_writes: %0d wrong writes want 0", badEn); end
      total++;
      if (doneCnt != 1 || wlog[65535].done !== 1'b1) begin
        bad++; $display("FAIL max_done: count=%0d last=%b want 1 1", doneCnt, wlog[65535].done);
      end
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL max_busy_fall: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_hold();
    test_reset_mid();
    test_max_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
